// File: rtl/frame_buffer_pkg.sv
// frame_buffer_pkg: shared types and defaults for the frame-buffer SDRAM arbiter.
package frame_buffer_pkg;
    typedef enum logic [1:0] {IDLE, CMD, BUSY} state_t;
    typedef logic [1:0] bufIdx_t;
    localparam logic GRANT_RD = 1'b0;
    localparam logic GRANT_WR = 1'b1;
    localparam int unsigned FRAME_WORDS_DEF = 307200;
    localparam int unsigned FRAME_STRIDE_DEF = 32'h0008_0000;
endpackage

// File: rtl/frame_buffer_arbiter_port_addr.sv
// fb_port_addr: per-port linear frame offset, burst length, frame wrap and pending frame-sync flag.
module fb_port_addr
    import frame_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W = 9,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF
)(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic              advance,
    input  logic              sync,
    input  logic              active,
    output logic [LEN_W-1:0]  len,
    output logic [ADDR_W-1:0] offset,
    output logic              frameLast,
    output logic              pending
);
    logic [ADDR_W-1:0] remain;
    logic syncApply;
    assign remain = ADDR_W'(FRAME_WORDS) - offset;
    assign len = remain < ADDR_W'(BURST_LEN) ? remain[LEN_W-1:0] : LEN_W'(BURST_LEN);
    assign frameLast = offset + ADDR_W'(len) == ADDR_W'(FRAME_WORDS);
    // A sync waits out the port's own burst so the offset reset lands after its advance.
    assign syncApply = pending && (!active || advance);
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            offset  <= '0;
            pending <= 1'b0;
        end else begin
            pending <= pending ? !syncApply : sync;
            offset  <= (syncApply || (advance && frameLast)) ? '0 : advance ? offset + ADDR_W'(len) : offset;
        end
    end
endmodule

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: schedules camera write and VGA read bursts on the frame-buffer SDRAM
// and rotates three frame buffers so the display never shows a partially written frame.
module frame_buffer_arbiter
    import frame_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = 23,
    parameter int unsigned LEN_W = 9,
    parameter int unsigned LVL_W = 10,
    parameter int unsigned BURST_LEN = 256,
    parameter int unsigned FRAME_WORDS = FRAME_WORDS_DEF,
    parameter int unsigned FRAME_STRIDE = FRAME_STRIDE_DEF,
    parameter int unsigned RD_FIFO_DEPTH = 512,
    parameter int unsigned RD_LOW_WM = 128
)(
    input  logic              iCLK,
    input  logic              iRST,
    input  logic [LVL_W-1:0]  iWR_LEVEL,
    input  logic [LVL_W-1:0]  iRD_LEVEL,
    input  logic              iWR_FRAME_START,
    input  logic              iRD_FRAME_START,
    output logic              oCMD_VALID,
    input  logic              iCMD_READY,
    output logic              oCMD_WRITE,
    output logic [ADDR_W-1:0] oCMD_ADDR,
    output logic [LEN_W-1:0]  oCMD_LEN,
    input  logic              iBURST_DONE,
    output logic [1:0]        oWR_BUF,
    output logic [1:0]        oRD_BUF,
    output logic              oFRAME_DROP
);
    state_t state, stateNext;
    bufIdx_t wb, rb, pb;
    logic pvalid, lastGrant;
    logic [LEN_W-1:0] lenWr, lenRd;
    logic [ADDR_W-1:0] offWr, offRd, nextAddr;
    logic lastWr, lastRd, pendWr, pendRd;
    logic wrElig, rdElig, urgent, grantWr;
    logic burstDone, wrActive, rdActive, wrFrameDone, rdSyncApply;

    assign burstDone   = state == BUSY && iBURST_DONE;
    assign wrActive    = state != IDLE && oCMD_WRITE;
    assign rdActive    = state != IDLE && !oCMD_WRITE;
    assign wrFrameDone = burstDone && oCMD_WRITE && (oCMD_WRITE ? lastWr : lastRd);
    assign rdSyncApply = pendRd && (!rdActive || (burstDone && !oCMD_WRITE));
    assign oWR_BUF = wb;
    assign oRD_BUF = rb;

    fb_port_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) uWr (
        .iCLK(iCLK), .iRST(iRST), .advance(burstDone && oCMD_WRITE), .sync(iWR_FRAME_START),
        .active(wrActive), .len(lenWr), .offset(offWr), .frameLast(lastWr), .pending(pendWr)
    );

    fb_port_addr #(.ADDR_W(ADDR_W), .LEN_W(LEN_W), .BURST_LEN(BURST_LEN), .FRAME_WORDS(FRAME_WORDS)) uRd (
        .iCLK(iCLK), .iRST(iRST), .advance(burstDone && !oCMD_WRITE), .sync(iRD_FRAME_START),
        .active(rdActive), .len(lenRd), .offset(offRd), .frameLast(lastRd), .pending(pendRd)
    );

    // A port with a sync about to apply sits out one decision so it never issues from a stale offset.
    always_comb begin
        wrElig    = !pendWr && 32'(iWR_LEVEL) >= 32'(lenWr);
        rdElig    = !pendRd && 32'(iRD_LEVEL) + 32'(lenRd) <= RD_FIFO_DEPTH;
        urgent    = rdElig && 32'(iRD_LEVEL) < RD_LOW_WM;
        grantWr   = !urgent && wrElig && (!rdElig || lastGrant == GRANT_RD);
        nextAddr  = ADDR_W'(32'(grantWr ? wb : rb) * FRAME_STRIDE + 32'(grantWr ? offWr : offRd));
        stateNext = state == IDLE ? ((wrElig || rdElig) ? CMD : IDLE) :
                    state == CMD  ? (iCMD_READY ? BUSY : CMD) :
                                    (iBURST_DONE ? IDLE : BUSY);
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) state <= IDLE;
        else      state <= stateNext;
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            oCMD_VALID <= 1'b0;
            oCMD_WRITE <= 1'b0;
            oCMD_ADDR  <= '0;
            oCMD_LEN   <= '0;
            lastGrant  <= GRANT_RD;
        end else if (state == IDLE && (wrElig || rdElig)) begin
            oCMD_VALID <= 1'b1;
            oCMD_WRITE <= grantWr;
            oCMD_ADDR  <= nextAddr;
            oCMD_LEN   <= grantWr ? lenWr : lenRd;
        end else if (state == CMD && iCMD_READY) begin
            oCMD_VALID <= 1'b0;
            lastGrant  <= oCMD_WRITE ? GRANT_WR : GRANT_RD;
        end
    end

    // A read sync coinciding with a finished write frame hands that frame straight to the display.
    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            wb <= 2'd0;
            rb <= 2'd1;
            pb <= 2'd0;
            pvalid <= 1'b0;
            oFRAME_DROP <= 1'b0;
        end else begin
            oFRAME_DROP <= wrFrameDone && !rdSyncApply && pvalid;
            if (wrFrameDone) begin
                wb <= 2'd3 - wb - rb;
                pb <= wb;
                pvalid <= !rdSyncApply;
                if (rdSyncApply) rb <= wb;
            end else if (rdSyncApply && pvalid) begin
                rb <= pb;
                pvalid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed vector table plus hand sequences for the frame-buffer arbiter.
module tb_frame_buffer_arbiter;
    logic iCLK = 1'b0;
    logic iRST = 1'b1;
    logic [9:0] iWR_LEVEL = 10'd300;
    logic [9:0] iRD_LEVEL = 10'd500;
    logic iWR_FRAME_START = 1'b0, iRD_FRAME_START = 1'b0;
    logic iCMD_READY = 1'b0, iBURST_DONE = 1'b0;
    logic oCMD_VALID, oCMD_WRITE, oFRAME_DROP;
    logic [22:0] oCMD_ADDR;
    logic [8:0] oCMD_LEN;
    logic [1:0] oWR_BUF, oRD_BUF;
    int compared = 0, mismatched = 0, dropCnt;

    typedef struct {
        logic [9:0] wr, rd;
        logic       w;
        int         addr, len;
        logic [1:0] wb, rb;
    } vec_t;
    vec_t tbl[12];

    frame_buffer_arbiter #(.FRAME_WORDS(1000), .FRAME_STRIDE(4096)) dut (
        .iCLK(iCLK), .iRST(iRST), .iWR_LEVEL(iWR_LEVEL), .iRD_LEVEL(iRD_LEVEL),
        .iWR_FRAME_START(iWR_FRAME_START), .iRD_FRAME_START(iRD_FRAME_START),
        .oCMD_VALID(oCMD_VALID), .iCMD_READY(iCMD_READY), .oCMD_WRITE(oCMD_WRITE),
        .oCMD_ADDR(oCMD_ADDR), .oCMD_LEN(oCMD_LEN), .iBURST_DONE(iBURST_DONE),
        .oWR_BUF(oWR_BUF), .oRD_BUF(oRD_BUF), .oFRAME_DROP(oFRAME_DROP)
    );

    always #5 iCLK = ~iCLK;

    always @(posedge iCLK or posedge iRST)
        if (iRST) dropCnt <= 0;
        else if (oFRAME_DROP) dropCnt <= dropCnt + 1;

    task automatic check(input string nm, input longint act, input longint exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got %0d, want %0d", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge iCLK);
        #1;
    endtask

    task automatic doReset(input logic [9:0] wr, input logic [9:0] rd);
        iRST = 1'b1; iWR_LEVEL = wr; iRD_LEVEL = rd;
        iCMD_READY = 1'b0; iBURST_DONE = 1'b0; iWR_FRAME_START = 1'b0; iRD_FRAME_START = 1'b0;
        tick(1);
        check("rst.valid", oCMD_VALID, 0);
        check("rst.write", oCMD_WRITE, 0);
        check("rst.addr", oCMD_ADDR, 0);
        check("rst.len", oCMD_LEN, 0);
        check("rst.wrbuf", oWR_BUF, 0);
        check("rst.rdbuf", oRD_BUF, 1);
        check("rst.drop", oFRAME_DROP, 0);
        iRST = 1'b0;
    endtask

    task automatic waitValid(input string nm);
        int n = 0;
        while (!oCMD_VALID && n < 50) begin
            tick(1);
            n++;
        end
        check({nm, ".valid"}, oCMD_VALID, 1);
    endtask

    task automatic burst(input string nm, input logic w, input int addr, input int len, input bit rdSync);
        waitValid(nm);
        check({nm, ".write"}, oCMD_WRITE, w);
        check({nm, ".addr"}, oCMD_ADDR, addr);
        check({nm, ".len"}, oCMD_LEN, len);
        iCMD_READY = 1'b1;
        tick(1);
        iCMD_READY = 1'b0;
        check({nm, ".dropvalid"}, oCMD_VALID, 0);
        tick(4);
        if (rdSync) begin
            iRD_FRAME_START = 1'b1;
            tick(1);
            iRD_FRAME_START = 1'b0;
        end
        tick(4);
        iBURST_DONE = 1'b1;
        tick(1);
        iBURST_DONE = 1'b0;
    endtask

    task automatic checkBufs(input string nm, input int w, input int r);
        check({nm, ".wrbuf"}, oWR_BUF, w);
        check({nm, ".rdbuf"}, oRD_BUF, r);
    endtask

    initial begin
        int acc;
        tbl[0]  = '{300, 500, 1, 0,    256, 0, 1};
        tbl[1]  = '{300, 500, 1, 256,  256, 0, 1};
        tbl[2]  = '{300, 500, 1, 512,  256, 0, 1};
        tbl[3]  = '{300, 500, 1, 768,  232, 2, 1};
        tbl[4]  = '{300, 500, 1, 8192, 256, 2, 1};
        tbl[5]  = '{300, 200, 0, 4096, 256, 2, 1};
        tbl[6]  = '{300, 200, 1, 8448, 256, 2, 1};
        tbl[7]  = '{300, 200, 0, 4352, 256, 2, 1};
        tbl[8]  = '{300, 200, 1, 8704, 256, 2, 1};
        tbl[9]  = '{300, 100, 0, 4608, 256, 2, 1};
        tbl[10] = '{300, 100, 0, 4864, 232, 2, 1};
        tbl[11] = '{300, 128, 1, 8960, 232, 0, 1};
        doReset(300, 500);
        foreach (tbl[i]) begin
            iWR_LEVEL = tbl[i].wr;
            iRD_LEVEL = tbl[i].rd;
            burst($sformatf("vec%0d", i), tbl[i].w, tbl[i].addr, tbl[i].len, 1'b0);
            checkBufs($sformatf("vec%0d", i), tbl[i].wb, tbl[i].rb);
        end

        // backpressure: command held stable, accepted exactly once
        doReset(300, 500);
        waitValid("t3");
        for (int k = 0; k < 5; k++) begin
            check("t3.hold.valid", oCMD_VALID, 1);
            check("t3.hold.addr", oCMD_ADDR, 0);
            check("t3.hold.len", oCMD_LEN, 256);
            tick(1);
        end
        acc = 0;
        iCMD_READY = 1'b1;
        for (int k = 0; k < 4; k++) begin
            if (oCMD_VALID) acc++;
            tick(1);
        end
        iCMD_READY = 1'b0;
        check("t3.accepts", acc, 1);
        iBURST_DONE = 1'b1;
        tick(1);
        iBURST_DONE = 1'b0;

        // triple buffering: read sync takes the finished frame, unread frames get dropped
        doReset(300, 500);
        burst("t4.f1a", 1, 0, 256, 0);
        burst("t4.f1b", 1, 256, 256, 0);
        burst("t4.f1c", 1, 512, 256, 0);
        burst("t4.f1d", 1, 768, 232, 0);
        iWR_LEVEL = 10'd0;
        checkBufs("t4.f1", 2, 1);
        iRD_FRAME_START = 1'b1;
        tick(1);
        iRD_FRAME_START = 1'b0;
        tick(2);
        checkBufs("t4.sync", 2, 0);
        iRD_LEVEL = 10'd200;
        burst("t4.rd", 0, 0, 256, 0);
        iRD_LEVEL = 10'd500;
        iWR_LEVEL = 10'd300;
        burst("t4.f2a", 1, 8192, 256, 0);
        burst("t4.f2b", 1, 8448, 256, 0);
        burst("t4.f2c", 1, 8704, 256, 0);
        burst("t4.f2d", 1, 8960, 232, 0);
        tick(2);
        check("t4.f2.drops", dropCnt, 0);
        checkBufs("t4.f2", 1, 0);
        burst("t4.f3a", 1, 4096, 256, 0);
        burst("t4.f3b", 1, 4352, 256, 0);
        burst("t4.f3c", 1, 4608, 256, 0);
        burst("t4.f3d", 1, 4864, 232, 0);
        iWR_LEVEL = 10'd0;
        tick(2);
        check("t4.f3.drops", dropCnt, 1);
        checkBufs("t4.f3", 2, 0);

        // read sync during a burst: offset restarts after that burst, display takes pending frame
        iRD_LEVEL = 10'd200;
        burst("t5.a", 0, 256, 256, 0);
        burst("t5.b", 0, 512, 256, 1);
        checkBufs("t5.sync", 2, 1);
        burst("t5.next", 0, 4096, 256, 0);

        // asynchronous reset while a burst is in flight, then while a command is offered
        iRD_LEVEL = 10'd500;
        iWR_LEVEL = 10'd300;
        waitValid("t6");
        iCMD_READY = 1'b1;
        tick(1);
        iCMD_READY = 1'b0;
        tick(3);
        #2 iRST = 1'b1;
        #1;
        check("t6.busy.valid", oCMD_VALID, 0);
        checkBufs("t6.busy", 0, 1);
        tick(1);
        iRST = 1'b0;
        burst("t6.after", 1, 0, 256, 0);
        waitValid("t6.cmd");
        #3 iRST = 1'b1;
        #1;
        check("t6.cmd.valid", oCMD_VALID, 0);
        check("t6.cmd.addr", oCMD_ADDR, 0);
        check("t6.cmd.len", oCMD_LEN, 0);
        tick(1);
        iRST = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", compared);
        $fatal(1, "watchdog");
    end
endmodule
